// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART byte transmitter
// among NUM_REQ valid/ready requesters, with optional release of a stalled grantee.
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_tx_valid,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] c_PTR_INIT = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] c_CNT_LAST = (IDLE_TIMEOUT > 0) ? CW'(IDLE_TIMEOUT - 1) : '0;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [PW-1:0]      r_gidx,  w_gidx_nxt;
  logic [PW-1:0]      r_ptr,   w_ptr_nxt;
  logic [CW-1:0]      r_cnt,   w_cnt_nxt;

  logic               w_found;
  logic [PW-1:0]      w_win;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic [7:0]         w_sel_data;
  logic               w_xfer;

  function automatic logic [PW-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // Scan starts just after the last served requester, so it gets lowest priority next.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && i_req_valid[wrap_idx(int'(r_ptr), i)]) begin
        w_found = 1'b1;
        w_win   = wrap_idx(int'(r_ptr), i);
      end
    end
  end

  assign w_sel_valid = i_req_valid[r_gidx];
  assign w_sel_last  = i_req_last[r_gidx];
  assign w_sel_data  = i_req_data[8*int'(r_gidx) +: 8];
  assign w_xfer      = (r_state == S_LOCKED) && w_sel_valid && i_tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= c_PTR_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    o_tx_valid  = 1'b0;
    o_tx_data   = 8'h00;
    o_req_ready = '0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_found) begin
          w_state_nxt        = S_LOCKED;
          w_grant_nxt        = '0;
          w_grant_nxt[w_win] = 1'b1;
          w_gidx_nxt         = w_win;
        end
      end
      S_LOCKED: begin
        o_tx_valid          = w_sel_valid;
        o_tx_data           = w_sel_data;
        o_req_ready[r_gidx] = i_tx_ready & w_sel_valid;
        if (w_sel_valid) begin
          w_cnt_nxt = '0;
          if (w_xfer && w_sel_last) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = r_gidx;
          end
        end else if (IDLE_TIMEOUT > 0) begin
          // The cycle that would bring the count to IDLE_TIMEOUT releases the grant.
          if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = r_gidx;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign o_grant = r_grant;
  assign o_busy  = (r_state == S_LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for uart_tx_arbiter with a byte scoreboard
// (expected bytes queued when stimulus is set up, popped on each tx transfer).
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NREQ = 2;
  localparam int TOUT = 16;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] i_req_valid;
  logic [8*NREQ-1:0] i_req_data;
  logic [NREQ-1:0] i_req_last;
  logic [NREQ-1:0] o_req_ready;
  logic            o_tx_valid;
  logic [7:0]      o_tx_data;
  logic            i_tx_ready;
  logic [NREQ-1:0] o_grant;
  logic            o_busy;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .IDLE_TIMEOUT(TOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_tx_valid  (o_tx_valid),
    .o_tx_data   (o_tx_data),
    .i_tx_ready  (i_tx_ready),
    .o_grant     (o_grant),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic l; } src_t;
  typedef struct { int r; logic [7:0] d; } exp_t;

  src_t src0[$];
  src_t src1[$];
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int rdy_period = 1;

  logic [NREQ-1:0] s_grant, s_rr;
  logic            s_busy, s_txv, s_xfer;
  logic [7:0]      s_txd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_src(input int r, input logic [7:0] d, input logic l);
    src_t s;
    exp_t e;
    s.d = d; s.l = l;
    e.r = r; e.d = d;
    if (r == 0) src0.push_back(s); else src1.push_back(s);
    exp_q.push_back(e);
  endtask

  // One clock: present queue heads, sample at negedge, retire accepted bytes after the edge.
  task automatic cycle();
    exp_t e;
    i_req_valid[0] = (src0.size() > 0);
    i_req_valid[1] = (src1.size() > 0);
    i_req_data[7:0]  = (src0.size() > 0) ? src0[0].d : 8'h00;
    i_req_last[0]    = (src0.size() > 0) ? src0[0].l : 1'b0;
    i_req_data[15:8] = (src1.size() > 0) ? src1[0].d : 8'h00;
    i_req_last[1]    = (src1.size() > 0) ? src1[0].l : 1'b0;
    if (rdy_period == 0)      i_tx_ready = 1'b0;
    else if (rdy_period == 1) i_tx_ready = 1'b1;
    else                      i_tx_ready = ((cyc % rdy_period) == 0);
    @(negedge clk);
    s_grant = o_grant; s_busy = o_busy; s_txv = o_tx_valid;
    s_txd = o_tx_data; s_rr = o_req_ready;
    s_xfer = s_txv && i_tx_ready;
    if (s_xfer) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_xfer", exp_q.size(), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", s_txd, e.d);
        chk("sb_grant", s_grant, 32'd1 << e.r);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_rr[0] && src0.size() > 0) void'(src0.pop_front());
    if (s_rr[1] && src1.size() > 0) void'(src1.pop_front());
  endtask

  task automatic run_until_empty(input int max, input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      cycle();
      n++;
    end
    chk(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    string msg;
    logic  found;
    logic [NREQ-1:0] g3 [7];
    msg = "<0123456789>";
    rst_n = 1'b0; i_req_valid = '0; i_req_data = '0; i_req_last = '0; i_tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", o_grant, 32'd0);
    chk("rst_busy",  o_busy, 32'd0);
    chk("rst_txv",   o_tx_valid, 32'd0);
    chk("rst_txd",   o_tx_data, 32'd0);
    chk("rst_rr",    o_req_ready, 32'd0);
    rst_n = 1'b1;

    // 1: both request 1-byte packets together, requester 0 first.
    push_src(0, 8'hA5, 1'b1);
    push_src(1, 8'h3C, 1'b1);
    rdy_period = 1;
    cycle(); chk("t1_c0_grant", s_grant, 32'b00);
    cycle(); chk("t1_c1_grant", s_grant, 32'b01);
    cycle(); chk("t1_c2_gap",   s_grant, 32'b00);
    cycle(); chk("t1_c3_grant", s_grant, 32'b10);
    cycle(); chk("t1_c4_idle",  {s_grant, s_busy}, 32'b000);
    chk("t1_empty", exp_q.size(), 32'd0);

    // 2: slow sink, requester 1 waits for the whole packet of requester 0.
    for (int i = 0; i < msg.len(); i++) push_src(0, msg[i], (i == msg.len() - 1));
    push_src(1, 8'h55, 1'b1);
    rdy_period = 234;
    found = 1'b0;
    for (int n = 0; n < 4000 && !found; n++) begin
      cycle();
      if (s_xfer && s_txd == 8'h3E) found = 1'b1;
    end
    chk("t2_last_seen", found, 32'd1);
    cycle(); chk("t2_gap",   s_grant, 32'b00);
    cycle(); chk("t2_grant", s_grant, 32'b10);
    run_until_empty(400, "t2_drain");
    rdy_period = 1;
    cycle();

    // 3: requester 1 alone, three back-to-back packets.
    push_src(1, 8'h11, 1'b1);
    push_src(1, 8'h22, 1'b1);
    push_src(1, 8'h33, 1'b1);
    g3 = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk($sformatf("t3_c%0d_grant", i), s_grant, g3[i]);
    end
    chk("t3_empty", exp_q.size(), 32'd0);

    // 4: requester 0 stalls mid-packet, released after TOUT idle cycles.
    push_src(0, 8'hA1, 1'b0);
    push_src(0, 8'hA2, 1'b0);
    push_src(1, 8'hB1, 1'b1);
    cycle(); chk("t4_c0_grant", s_grant, 32'b00);
    cycle(); chk("t4_c1_grant", s_grant, 32'b01);
    cycle(); chk("t4_c2_xfer",  s_xfer, 32'd1);
    for (int i = 0; i < TOUT; i++) cycle();
    chk("t4_held",     s_grant, 32'b01);
    cycle(); chk("t4_release", {s_grant, s_busy}, 32'b000);
    cycle(); chk("t4_next",    s_grant, 32'b10);
    chk("t4_empty", exp_q.size(), 32'd0);
    cycle();

    // 6: sink stalled with valid data, outputs hold, no timeout.
    src0.push_back('{d: 8'hC1, l: 1'b0});
    src0.push_back('{d: 8'hC2, l: 1'b1});
    rdy_period = 0;
    cycle();
    for (int i = 0; i < 100; i++) begin
      cycle();
      chk("t6_hold", {s_grant, s_rr, s_txv, s_txd}, {2'b01, 2'b00, 1'b1, 8'hC1});
    end
    exp_q.push_back('{r: 0, d: 8'hC1});
    exp_q.push_back('{r: 0, d: 8'hC2});
    rdy_period = 1;
    run_until_empty(20, "t6_drain");
    cycle();

    // 5: asynchronous reset mid-packet, then requester 0 regains first priority.
    src1.push_back('{d: 8'hD1, l: 1'b0});
    src1.push_back('{d: 8'hD2, l: 1'b0});
    rdy_period = 0;
    cycle();
    cycle(); chk("t5_pre_txv", s_txv, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async", {o_grant, o_busy, o_tx_valid, o_req_ready}, 32'd0);
    src0.delete(); src1.delete();
    i_req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_src(0, 8'hE0, 1'b1);
    push_src(1, 8'hE1, 1'b1);
    rdy_period = 1;
    run_until_empty(20, "t5_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
